minibus_arbiter: RTL
====================

MINIBUS_ARBITER -- requirements
Module: minibus_arbiter

Interface
REQ-001 Parameter MASTER_COUNT, default 2, SHALL set the number of upstream minibus masters (range 2..8).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 nrst  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 _masterifs  minibus_master_if.arbiter [MASTER_COUNT]  SHALL carry one req in and one res out per upstream master.
REQ-005 _busif  minibus_master_if.master  1  SHALL drive the single req to, and take the res from, minibus_decoder.
REQ-006 grant_idx  output  $clog2(MASTER_COUNT)  SHALL give the index of the currently granted master.
REQ-007 busy  output  1  SHALL be 1 while a transfer is granted.

Function
REQ-008 A master request SHALL be pending when req.ren or req.wen is 1.
REQ-009 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-010 In IDLE with at least one pending request:
  - the arbiter SHALL select a winner per REQ-016;
  - it SHALL register grant_idx;
  - it SHALL enter GRANT on the next edge (1-cycle arbitration latency).
REQ-011 In IDLE, _busif.req SHALL be all zeros.
REQ-012 In GRANT:
  - _busif.req SHALL equal the req of _masterifs[grant_idx];
  - every master SHALL receive _busif.res data;
  - only the granted master SHALL see res.ready; all others see ready=0.
REQ-013 In GRANT, a cycle with _busif.res.ready=1 SHALL complete the transfer:
  - the FSM SHALL return to IDLE on the next edge;
  - at most one transfer SHALL complete per grant.
REQ-014 If the granted master drops ren and wen in GRANT before ready, the arbiter SHALL abort to IDLE on the next edge, with no ready delivered.
REQ-015 A master SHALL hold its req stable from assertion until it sees ready; the arbiter does not re-sample the winner during GRANT.
REQ-016 Winner selection SHALL follow REQ-024/REQ-025.
  - The last-served pointer SHALL update only on completion, not on abort.
REQ-017 Requests arriving during GRANT SHALL wait; no request SHALL be dropped.
REQ-018 busy SHALL be 1 exactly when the state is GRANT.
REQ-019 grant_idx SHALL hold its value while in IDLE.

Reset
REQ-020 While nrst=0 at a clock edge, all of the following SHALL hold:
  - state <= IDLE;
  - grant_idx <= 0;
  - round-robin pointer <= MASTER_COUNT-1, so master 0 wins first;
  - busy=0;
  - _busif.req all zeros.
REQ-021 Reset asserted during GRANT SHALL abandon the transfer; no ready SHALL be forwarded in the reset cycle.
REQ-022 The first arbitration after reset release SHALL occur at the first edge with nrst=1.

Configuration
REQ-023 The macro MINIBUS_ARBITER_RR_EN SHALL select the arbitration policy.
REQ-024 With MINIBUS_ARBITER_RR_EN defined, selection SHALL be round-robin: the first pending index after the last-served pointer, cyclically, wraps MASTER_COUNT-1 -> 0.
REQ-025 Without it, selection SHALL be fixed priority (lowest pending index wins), and no pointer register SHALL exist.

Structure
REQ-026 The arbiter state enum (IDLE, GRANT) SHALL live in minibus_pkg, alongside the existing request/response typedefs.
REQ-027 minibus_master_if SHALL gain an "arbiter" modport: req input, res output.
REQ-028 A sub-module minibus_rr_picker SHALL contain the combinational selection logic.
  - Inputs: pending vector, pointer.
  - Outputs: winner index, valid.
  - It SHALL compile to priority logic when MINIBUS_ARBITER_RR_EN is undefined.

Verification
REQ-029 Single master: m0 reads addr 0x100, slave gives ready at GRANT cycle 3.
  - busy=1 from cycle 1 to 3; m0 sees ready once; IDLE at cycle 4.
REQ-030 Simultaneous: m0 and m1 request at the same cycle after reset.
  - RR: m0 served first, then m1.
  - Fixed priority with m0 re-requesting: m0 is served twice before m1.
REQ-031 RR wrap: MASTER_COUNT=4, last served 3, m1 and m3 pending -> m1 granted.
REQ-032 Abort: m1 granted, drops wen at GRANT cycle 2.
  - IDLE next cycle; pointer unchanged; m1 sees no ready.
REQ-033 Reset mid-transfer: nrst=0 during GRANT with slave ready=1.
  - No master sees ready; busy=0 and grant_idx=0 after the edge.
REQ-034 Isolation: m1 granted, m0 pending -> m0 ready stays 0 throughout; _busif.req.addr equals m1's addr.

Source files
------------

// File: rtl/minibus_pkg.sv
// -----------------------------------------------------------------------------
// minibus_pkg
// Shared minibus types: request/response structs carried by minibus_master_if
// and the arbiter FSM state enum used by minibus_arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package minibus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  // Master -> slave request. A request is pending while ren or wen is 1.
  typedef struct packed {
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } minibus_req_t;

  // Slave -> master response. ready=1 completes the current transfer.
  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] rdata;
  } minibus_res_t;

  // Arbiter FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/minibus_master_if.sv
// -----------------------------------------------------------------------------
// minibus_master_if
// One minibus link: a request travelling towards the slave side and a
// response travelling back.
// Modports:
//   master  : drives req, receives res (a bus master, or the arbiter's
//             downstream side towards minibus_decoder)
//   arbiter : receives req, drives res (the arbiter's upstream side)
// -----------------------------------------------------------------------------
interface minibus_master_if;
  import minibus_pkg::*;

  minibus_req_t req;
  minibus_res_t res;

  modport master  (output req, input  res);
  modport arbiter (input  req, output res);

endinterface

// File: rtl/minibus_rr_picker.sv
// -----------------------------------------------------------------------------
// minibus_rr_picker
// Combinational winner selection for minibus_arbiter.
// Build option: MINIBUS_ARBITER_RR_EN
//   defined   : round-robin, first pending index strictly after i_ptr,
//               wrapping N-1 -> 0
//   undefined : fixed priority, lowest pending index wins, i_ptr ignored
// Ports:
//   i_pending [N]     : one bit per master, 1 = request pending
//   i_ptr     [IDX_W] : index of the last served master
//   o_winner  [IDX_W] : selected master (0 when o_valid=0)
//   o_valid           : 1 when any request is pending
// -----------------------------------------------------------------------------
module minibus_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_pending,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_valid
);

`ifdef MINIBUS_ARBITER_RR_EN
  logic             w_hi_found;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;

  // Scan downwards so the last hit is the lowest index. The lowest pending
  // index above the pointer wins; otherwise wrap to the lowest pending index.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    o_valid    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_pending[i]) begin
        w_lo_idx = IDX_W'(i);
        o_valid  = 1'b1;
        if (i > int'(i_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDX_W'(i);
        end
      end
    end
    o_winner = w_hi_found ? w_hi_idx : w_lo_idx;
  end
`else
  // Fixed priority has no notion of history; the pointer input is unused.
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_pending[i]) begin
        o_winner = IDX_W'(i);
        o_valid  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/minibus_arbiter.sv
// -----------------------------------------------------------------------------
// minibus_arbiter
// Shares one downstream minibus link between MASTER_COUNT upstream masters.
// Build option: MINIBUS_ARBITER_RR_EN selects round-robin arbitration;
// without it arbitration is fixed priority (lowest index) and no last-served
// pointer register exists.
// Ports:
//   clk          : clock, rising edge
//   nrst         : synchronous active-low reset
//   _masterifs[] : upstream links (req in, res out), one per master
//   _busif       : downstream link to minibus_decoder (req out, res in)
//   grant_idx    : index of the granted master, held while idle
//   busy         : 1 while in GRANT
//   o_dbg_state  : current FSM state
// Handshake: a master raises ren/wen and holds its req stable until it sees
// res.ready=1 for exactly one cycle; dropping ren/wen before ready aborts.
// The arbiter registers the winner in IDLE (one cycle of latency) and then
// forwards only that master's req downstream until ready or abort.
// -----------------------------------------------------------------------------
module minibus_arbiter
  import minibus_pkg::*;
#(
  parameter int MASTER_COUNT = 2
) (
  input  logic                            clk,
  input  logic                            nrst,
  minibus_master_if.arbiter               _masterifs [MASTER_COUNT],
  minibus_master_if.master                _busif,
  output logic [$clog2(MASTER_COUNT)-1:0] grant_idx,
  output logic                            busy,
  output arb_state_e                      o_dbg_state
);

  localparam int IDX_W = $clog2(MASTER_COUNT);

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [IDX_W-1:0]       r_grant_idx;
  logic [IDX_W-1:0]       w_grant_idx_nxt;
  logic [IDX_W-1:0]       w_ptr;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;
  logic [MASTER_COUNT-1:0] w_pending;
  logic                   w_granted;
  minibus_req_t           w_reqs [MASTER_COUNT];

  // Interface arrays only take constant indices, so flatten the upstream
  // requests into a plain array and drive each response individually.
  // Outside reset and GRANT no master sees ready; rdata is broadcast.
  for (genvar gi = 0; gi < MASTER_COUNT; gi++) begin : g_master
    assign w_reqs[gi]    = _masterifs[gi].req;
    assign w_pending[gi] = _masterifs[gi].req.ren | _masterifs[gi].req.wen;
    assign _masterifs[gi].res = '{
      ready: w_granted && (r_grant_idx == IDX_W'(gi)) && _busif.res.ready,
      rdata: _busif.res.rdata
    };
  end

  // Gating with nrst keeps the downstream request quiet and suppresses
  // ready during a reset cycle that interrupts a transfer.
  assign w_granted   = (r_state == GRANT) && nrst;
  assign _busif.req  = w_granted ? w_reqs[r_grant_idx] : '0;
  assign grant_idx   = r_grant_idx;
  assign busy        = (r_state == GRANT);
  assign o_dbg_state = r_state;

`ifdef MINIBUS_ARBITER_RR_EN
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  minibus_rr_picker #(
    .N     (MASTER_COUNT),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_pending (w_pending),
    .i_ptr     (w_ptr),
    .o_winner  (w_pick_idx),
    .o_valid   (w_pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
`ifdef MINIBUS_ARBITER_RR_EN
      // Last served = MASTER_COUNT-1 so master 0 is first in line.
      r_ptr       <= IDX_W'(MASTER_COUNT - 1);
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_idx_nxt;
`ifdef MINIBUS_ARBITER_RR_EN
      r_ptr       <= w_ptr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_idx_nxt = r_grant_idx;
`ifdef MINIBUS_ARBITER_RR_EN
    w_ptr_nxt       = r_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt     = GRANT;
          w_grant_idx_nxt = w_pick_idx;
        end
      end
      GRANT: begin
        // Completion moves the pointer; an abort leaves it alone.
        if (_busif.res.ready) begin
          w_state_nxt = IDLE;
`ifdef MINIBUS_ARBITER_RR_EN
          w_ptr_nxt   = r_grant_idx;
`endif
        end else if (!w_pending[r_grant_idx]) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
